// File: rtl/predictor_stat_table.sv
// Eight-entry table of per-predictor (SP/LHP/GHP) stat and trend counters with a registered read port and chooser.
// Optional macro PREDICTOR_STAT_BYPASS_EN forwards same-cycle write data to the read outputs.
module predictor_stat_table #(
  parameter int STAT_COUNTER_WIDTH = 5,
  parameter int ENTRIES            = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        WR_SP_en1,
  input  logic                        WR_LHP_en1,
  input  logic                        WR_GHP_en1,
  input  logic                        WR_SP_en2,
  input  logic                        WR_LHP_en2,
  input  logic                        WR_GHP_en2,
  input  logic [2:0]                  wr_index1,
  input  logic [2:0]                  wr_index2,
  input  logic [2:0]                  WR_SP_trend_count1,
  input  logic [2:0]                  WR_LHP_trend_count1,
  input  logic [2:0]                  WR_GHP_trend_count1,
  input  logic [2:0]                  WR_SP_trend_count2,
  input  logic [2:0]                  WR_LHP_trend_count2,
  input  logic [2:0]                  WR_GHP_trend_count2,
  input  logic [STAT_COUNTER_WIDTH:0] WR_SP_stat_count1,
  input  logic [STAT_COUNTER_WIDTH:0] WR_LHP_stat_count1,
  input  logic [STAT_COUNTER_WIDTH:0] WR_GHP_stat_count1,
  input  logic [STAT_COUNTER_WIDTH:0] WR_SP_stat_count2,
  input  logic [STAT_COUNTER_WIDTH:0] WR_LHP_stat_count2,
  input  logic [STAT_COUNTER_WIDTH:0] WR_GHP_stat_count2,
  input  logic                        clear_en,
  input  logic [2:0]                  rd_index,
  output logic [STAT_COUNTER_WIDTH-1:0] SP_stat_count,
  output logic [STAT_COUNTER_WIDTH-1:0] LHP_stat_count,
  output logic [STAT_COUNTER_WIDTH-1:0] GHP_stat_count,
  output logic [2:0]                  SP_trend_count,
  output logic [2:0]                  LHP_trend_count,
  output logic [2:0]                  GHP_trend_count,
  output logic [1:0]                  select
);

  localparam int W  = STAT_COUNTER_WIDTH;
  localparam int NP = 3;

  typedef enum logic [1:0] {
    SEL_SP  = 2'b00,
    SEL_LHP = 2'b01,
    SEL_GHP = 2'b10
  } sel_e;

  logic         wr_en1   [NP];
  logic         wr_en2   [NP];
  logic [2:0]   wr_trend1[NP];
  logic [2:0]   wr_trend2[NP];
  logic [W:0]   wr_stat1 [NP];
  logic [W:0]   wr_stat2 [NP];

  logic [W-1:0] stat_q   [NP][ENTRIES];
  logic [W-1:0] stat_d   [NP][ENTRIES];
  logic [2:0]   trend_q  [NP][ENTRIES];
  logic [2:0]   trend_d  [NP][ENTRIES];

  logic [W-1:0] rd_stat_q [NP];
  logic [W-1:0] rd_stat_d [NP];
  logic [2:0]   rd_trend_q[NP];
  logic [2:0]   rd_trend_d[NP];
  sel_e         select_q;
  sel_e         select_d;

  // Saturate on carry, then halve when an aging pass happens in the same cycle.
  function automatic logic [W-1:0] condition_stat(input logic [W:0] raw, input logic age);
    logic [W-1:0] v;
    v = raw[W] ? {W{1'b1}} : raw[W-1:0];
    if (age) v = v >> 1;
    return v;
  endfunction

  always_comb begin
    wr_en1[0]    = WR_SP_en1;
    wr_en1[1]    = WR_LHP_en1;
    wr_en1[2]    = WR_GHP_en1;
    wr_en2[0]    = WR_SP_en2;
    wr_en2[1]    = WR_LHP_en2;
    wr_en2[2]    = WR_GHP_en2;
    wr_trend1[0] = WR_SP_trend_count1;
    wr_trend1[1] = WR_LHP_trend_count1;
    wr_trend1[2] = WR_GHP_trend_count1;
    wr_trend2[0] = WR_SP_trend_count2;
    wr_trend2[1] = WR_LHP_trend_count2;
    wr_trend2[2] = WR_GHP_trend_count2;
    wr_stat1[0]  = WR_SP_stat_count1;
    wr_stat1[1]  = WR_LHP_stat_count1;
    wr_stat1[2]  = WR_GHP_stat_count1;
    wr_stat2[0]  = WR_SP_stat_count2;
    wr_stat2[1]  = WR_LHP_stat_count2;
    wr_stat2[2]  = WR_GHP_stat_count2;
  end

  // Port 2 is applied last so it overrides port 1 on a same-index collision.
  always_comb begin
    stat_d  = stat_q;
    trend_d = trend_q;
    for (int p = 0; p < NP; p++) begin
      if (clear_en) begin
        for (int e = 0; e < ENTRIES; e++) begin
          stat_d[p][e] = stat_q[p][e] >> 1;
        end
      end
      if (wr_en1[p]) begin
        stat_d[p][wr_index1]  = condition_stat(wr_stat1[p], clear_en);
        trend_d[p][wr_index1] = wr_trend1[p];
      end
      if (wr_en2[p]) begin
        stat_d[p][wr_index2]  = condition_stat(wr_stat2[p], clear_en);
        trend_d[p][wr_index2] = wr_trend2[p];
      end
    end
  end

  always_comb begin
    for (int p = 0; p < NP; p++) begin
      rd_stat_d[p]  = stat_q[p][rd_index];
      rd_trend_d[p] = trend_q[p][rd_index];
`ifdef PREDICTOR_STAT_BYPASS_EN
      if (wr_en1[p] && (wr_index1 == rd_index)) begin
        rd_stat_d[p]  = condition_stat(wr_stat1[p], clear_en);
        rd_trend_d[p] = wr_trend1[p];
      end
      if (wr_en2[p] && (wr_index2 == rd_index)) begin
        rd_stat_d[p]  = condition_stat(wr_stat2[p], clear_en);
        rd_trend_d[p] = wr_trend2[p];
      end
`endif
    end
  end

  // Ties resolve towards GHP first, then LHP.
  always_comb begin
    select_d = SEL_SP;
    if ((rd_stat_d[2] >= rd_stat_d[1]) && (rd_stat_d[2] >= rd_stat_d[0])) begin
      select_d = SEL_GHP;
    end else if (rd_stat_d[1] >= rd_stat_d[0]) begin
      select_d = SEL_LHP;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < NP; p++) begin
        for (int e = 0; e < ENTRIES; e++) begin
          stat_q[p][e]  <= '0;
          trend_q[p][e] <= '0;
        end
        rd_stat_q[p]  <= '0;
        rd_trend_q[p] <= '0;
      end
      select_q <= SEL_GHP;
    end else begin
      stat_q     <= stat_d;
      trend_q    <= trend_d;
      rd_stat_q  <= rd_stat_d;
      rd_trend_q <= rd_trend_d;
      select_q   <= select_d;
    end
  end

  assign SP_stat_count   = rd_stat_q[0];
  assign LHP_stat_count  = rd_stat_q[1];
  assign GHP_stat_count  = rd_stat_q[2];
  assign SP_trend_count  = rd_trend_q[0];
  assign LHP_trend_count = rd_trend_q[1];
  assign GHP_trend_count = rd_trend_q[2];
  assign select          = select_q;

endmodule

// File: tb/tb_predictor_stat_table.sv
// Randomized self-checking bench for predictor_stat_table against a behavioural table model.
// Honours PREDICTOR_STAT_BYPASS_EN when computing expected read data.
module tb_predictor_stat_table;

   localparam int W      = 5;
   localparam int SATMAX = (1 << W) - 1;

   logic clk = 1'b0;
   logic rst;
   logic en1[3];
   logic en2[3];
   logic [2:0] idx1;
   logic [2:0] idx2;
   logic [2:0] rd;
   logic [2:0] tr1[3];
   logic [2:0] tr2[3];
   logic [W:0] st1[3];
   logic [W:0] st2[3];
   logic clr;

   logic [W-1:0] spStat, lhpStat, ghpStat;
   logic [2:0] spTrend, lhpTrend, ghpTrend;
   logic [1:0] sel;

   int mStat[3][8];
   int mTrend[3][8];
   int expStat[3];
   int expTrend[3];
   int expSel;
   int checkCount = 0;
   int passCount = 0;

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   predictor_stat_table #(.STAT_COUNTER_WIDTH(W), .ENTRIES(8)) dut (
      .clk(clk), .rst(rst),
      .WR_SP_en1(en1[0]), .WR_LHP_en1(en1[1]), .WR_GHP_en1(en1[2]),
      .WR_SP_en2(en2[0]), .WR_LHP_en2(en2[1]), .WR_GHP_en2(en2[2]),
      .wr_index1(idx1), .wr_index2(idx2),
      .WR_SP_trend_count1(tr1[0]), .WR_LHP_trend_count1(tr1[1]), .WR_GHP_trend_count1(tr1[2]),
      .WR_SP_trend_count2(tr2[0]), .WR_LHP_trend_count2(tr2[1]), .WR_GHP_trend_count2(tr2[2]),
      .WR_SP_stat_count1(st1[0]), .WR_LHP_stat_count1(st1[1]), .WR_GHP_stat_count1(st1[2]),
      .WR_SP_stat_count2(st2[0]), .WR_LHP_stat_count2(st2[1]), .WR_GHP_stat_count2(st2[2]),
      .clear_en(clr), .rd_index(rd),
      .SP_stat_count(spStat), .LHP_stat_count(lhpStat), .GHP_stat_count(ghpStat),
      .SP_trend_count(spTrend), .LHP_trend_count(lhpTrend), .GHP_trend_count(ghpTrend),
      .select(sel)
   );

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input int observed, input int expected);
      checkCount++;
      if (observed == expected) passCount++;
      else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
   endtask

   // Stored stat value: carry means saturate, aging halves it.
   function automatic int storedStat(input logic [W:0] raw, input logic age);
      int v;
      v = raw[W] ? SATMAX : int'(raw[W-1:0]);
      if (age) v = v / 2;
      return v;
   endfunction

   // Drop every write/clear request and read entry 0.
   task automatic clearInputs();
      for (int p = 0; p < 3; p++) begin
         en1[p] = 1'b0; en2[p] = 1'b0;
         tr1[p] = '0;   tr2[p] = '0;
         st1[p] = '0;   st2[p] = '0;
      end
      idx1 = '0; idx2 = '0; rd = '0; clr = 1'b0;
   endtask

   // Random traffic: frequent writes, occasional aging, random indices.
   task automatic applyStimulus();
      for (int p = 0; p < 3; p++) begin
         en1[p] = ($urandom_range(0, 99) < 40);
         en2[p] = ($urandom_range(0, 99) < 40);
         tr1[p] = 3'($urandom);
         tr2[p] = 3'($urandom);
         st1[p] = (W+1)'($urandom);
         st2[p] = (W+1)'($urandom);
      end
      idx1 = 3'($urandom_range(0, 7));
      idx2 = ($urandom_range(0, 3) == 0) ? idx1 : 3'($urandom_range(0, 7));
      rd   = ($urandom_range(0, 3) == 0) ? idx2 : 3'($urandom_range(0, 7));
      clr  = ($urandom_range(0, 99) < 15);
   endtask

   task automatic resetModel();
      for (int p = 0; p < 3; p++)
         for (int e = 0; e < 8; e++) begin
            mStat[p][e] = 0;
            mTrend[p][e] = 0;
         end
   endtask

   // Predict the read for this edge, update the model, then compare after the edge.
   task automatic stepAndCheck(input string tag);
      int best;
      for (int p = 0; p < 3; p++) begin
         expStat[p]  = mStat[p][rd];
         expTrend[p] = mTrend[p][rd];
`ifdef PREDICTOR_STAT_BYPASS_EN
         if (en1[p] && idx1 == rd) begin expStat[p] = storedStat(st1[p], clr); expTrend[p] = tr1[p]; end
         if (en2[p] && idx2 == rd) begin expStat[p] = storedStat(st2[p], clr); expTrend[p] = tr2[p]; end
`endif
      end
      best = expStat[0];
      if (expStat[1] > best) best = expStat[1];
      if (expStat[2] > best) best = expStat[2];
      expSel = (expStat[2] == best) ? 2 : (expStat[1] == best) ? 1 : 0;
      if (clr)
         for (int p = 0; p < 3; p++)
            for (int e = 0; e < 8; e++) mStat[p][e] = mStat[p][e] / 2;
      for (int p = 0; p < 3; p++) begin
         if (en1[p]) begin mStat[p][idx1] = storedStat(st1[p], clr); mTrend[p][idx1] = tr1[p]; end
         if (en2[p]) begin mStat[p][idx2] = storedStat(st2[p], clr); mTrend[p][idx2] = tr2[p]; end
      end
      @(posedge clk);
      #1;
      checkOutput({tag, "_sp_stat"},   spStat,   expStat[0]);
      checkOutput({tag, "_lhp_stat"},  lhpStat,  expStat[1]);
      checkOutput({tag, "_ghp_stat"},  ghpStat,  expStat[2]);
      checkOutput({tag, "_sp_trend"},  spTrend,  expTrend[0]);
      checkOutput({tag, "_lhp_trend"}, lhpTrend, expTrend[1]);
      checkOutput({tag, "_ghp_trend"}, ghpTrend, expTrend[2]);
      checkOutput({tag, "_select"},    sel,      expSel);
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      clearInputs();
      resetModel();
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_sp_stat", spStat, 0);
      checkOutput("rst_ghp_trend", ghpTrend, 0);
      checkOutput("rst_select", sel, 2);
      rst = 1'b0;

      // Read of an untouched entry after reset.
      clearInputs(); rd = 3'd3;
      stepAndCheck("read3");
      checkOutput("read3_select_const", sel, 2);

      // Port-1 LHP write, then read it back.
      clearInputs(); en1[1] = 1'b1; idx1 = 3'd5; st1[1] = 6'b0_00111; tr1[1] = 3'b010;
      stepAndCheck("lhp_wr");
      clearInputs(); rd = 3'd5;
      stepAndCheck("lhp_rd");
      checkOutput("lhp_rd_const", lhpStat, 7);
      checkOutput("lhp_rd_sel_const", sel, 1);

      // Same-index collision on SP: port 2 must win.
      clearInputs(); en1[0] = 1'b1; en2[0] = 1'b1; idx1 = 3'd2; idx2 = 3'd2; st1[0] = 6'd4; st2[0] = 6'd9;
      stepAndCheck("coll_wr");
      clearInputs(); rd = 3'd2;
      stepAndCheck("coll_rd");
      checkOutput("coll_rd_const", spStat, 9);

      // Saturating GHP write, then aging.
      clearInputs(); en1[2] = 1'b1; idx1 = 3'd0; st1[2] = 6'b1_00000;
      stepAndCheck("sat_wr");
      clearInputs(); clr = 1'b1; rd = 3'd0;
      stepAndCheck("sat_clr");
      checkOutput("sat_const", ghpStat, 31);
      clearInputs(); rd = 3'd0;
      stepAndCheck("aged_rd");
      checkOutput("aged_const", ghpStat, 15);

      // Write and read the same index in one cycle.
      clearInputs(); en1[0] = 1'b1; idx1 = 3'd1; st1[0] = 6'd10; rd = 3'd1;
      stepAndCheck("byp_wr");
`ifdef PREDICTOR_STAT_BYPASS_EN
      checkOutput("byp_same_const", spStat, 10);
`else
      checkOutput("byp_same_const", spStat, 0);
`endif
      clearInputs(); rd = 3'd1;
      stepAndCheck("byp_next");
      checkOutput("byp_next_const", spStat, 10);

      for (int i = 0; i < 400; i++) begin
         applyStimulus();
         stepAndCheck("rand");
      end

      // Asynchronous reset in the middle of a write cycle.
      clearInputs(); en1[0] = 1'b1; en2[2] = 1'b1; idx1 = 3'd4; idx2 = 3'd4; st1[0] = 6'd20; st2[2] = 6'd12; rd = 3'd4;
      #2 rst = 1'b1;
      #1;
      checkOutput("arst_sp_stat", spStat, 0);
      checkOutput("arst_lhp_stat", lhpStat, 0);
      checkOutput("arst_ghp_stat", ghpStat, 0);
      checkOutput("arst_sp_trend", spTrend, 0);
      checkOutput("arst_select", sel, 2);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      resetModel();
      clearInputs(); rd = 3'd4;
      stepAndCheck("arst_rd");
      checkOutput("arst_rd_const", ghpStat, 0);

      for (int i = 0; i < 100; i++) begin
         applyStimulus();
         stepAndCheck("rand2");
      end

      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/predictor_stat_table.md
PREDICTOR_STAT_TABLE -- requirements
Module: predictor_stat_table

Interface
REQ-001 SHALL have parameter STAT_COUNTER_WIDTH, default 5: stat counter width per predictor per entry.
REQ-002 SHALL have parameter ENTRIES, default 8, fixed at 8: table depth; index width is 3.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous reset, active-high.
REQ-005 SHALL have ports WR_SP_en1, WR_LHP_en1, WR_GHP_en1, inputs, 1 each: port-1 write enables (ID rollback).
REQ-006 SHALL have ports WR_SP_en2, WR_LHP_en2, WR_GHP_en2, inputs, 1 each: port-2 write enables (prediction/EX rollback).
REQ-007 SHALL have ports wr_index1, wr_index2, inputs, 3 each: entry index per write port.
REQ-008 SHALL have ports WR_{SP,LHP,GHP}_trend_count{1,2}, inputs, 3 each: trend values to store.
REQ-009 SHALL have ports WR_{SP,LHP,GHP}_stat_count{1,2}, inputs, STAT_COUNTER_WIDTH+1 each: stat values; MSB is the carry.
REQ-010 SHALL have port clear_en, input, 1: global stat-aging request.
REQ-011 SHALL have port rd_index, input, 3: read index.
REQ-012 SHALL have ports {SP,LHP,GHP}_stat_count, outputs, STAT_COUNTER_WIDTH each: registered stat counts of rd_index.
REQ-013 SHALL have ports {SP,LHP,GHP}_trend_count, outputs, 3 each: registered trend counts of rd_index.
REQ-014 SHALL have port select, output, 2: registered chooser; 2'b00 SP, 2'b01 LHP, 2'b10 GHP.

Function
REQ-015 SHALL store, per entry and per predictor (SP/LHP/GHP), one stat counter and one 3-bit trend counter.
REQ-016 SHALL, when a write enable is high on a rising edge, write that predictor's trend and stat fields at the port's index.
REQ-017 SHALL store stat as all-ones (saturate) when the written value's MSB is 1, else as its low STAT_COUNTER_WIDTH bits.
REQ-018 SHALL, when both ports write the same predictor at the same index in one cycle, keep port 2's data (port 2 wins).
REQ-019 SHALL, on a cycle with clear_en high, right-shift by 1 every stat counter of all 8 entries and all three predictors; trend counters unchanged.
REQ-020 SHALL, when clear_en and a write coincide, store written stat data shifted right by 1 (after saturation); other entries age normally.
REQ-021 SHALL register read outputs: value of rd_index sampled at edge N appears after edge N; latency 1 cycle.
REQ-022 SHALL compute select from the stat counts of rd_index as the predictor with the largest count; ties go GHP over LHP over SP.
REQ-023 SHALL, with all three counts equal (including all zero), output select = 2'b10.
REQ-024 SHALL ignore rd_index/wr_index values only via enables; all 8 indices are valid, no out-of-range case exists.

Reset
REQ-025 SHALL, while rst is high, immediately clear all table stat and trend counters to 0 and all outputs to 0, except select = 2'b10.
REQ-026 SHALL discard any write or clear_en in a cycle where rst is asserted at the edge; reset mid-operation leaves no partial update.
REQ-027 SHALL resume normal updates on the first rising edge after rst deasserts.

Configuration
REQ-028 SHALL support macro PREDICTOR_STAT_BYPASS_EN.
REQ-029 SHALL, with PREDICTOR_STAT_BYPASS_EN defined, forward same-cycle write data (port 2 over port 1, post-saturation, post-aging) to read outputs and select when wr_index equals rd_index.
REQ-030 SHALL, without PREDICTOR_STAT_BYPASS_EN, register the pre-write table contents at rd_index; the new value is visible one cycle later.

Verification
REQ-031 SHALL cover: reset, then read index 3 -> all stat/trend outputs 0, select 2'b10.
REQ-032 SHALL cover: port 1 writes LHP idx 5 stat 6'b0_00111 trend 3'b010, then read 5 -> LHP_stat_count 7, LHP_trend_count 2, select 2'b01.
REQ-033 SHALL cover: both ports write SP idx 2 (port1 stat 4, port2 stat 9) same cycle -> SP_stat_count reads 9.
REQ-034 SHALL cover: write GHP stat 6'b1_00000 at idx 0 -> stored 31 (saturated); next cycle clear_en -> reads 15.
REQ-035 SHALL cover: write SP idx 1 stat 10 and read idx 1 same cycle -> with BYPASS_EN output 10 next cycle; without it output old value 0, then 10 one cycle later.
REQ-036 SHALL cover: rst asserted asynchronously between edges during writes -> outputs 0 and select 2'b10 immediately; table reads 0 after release.
